// File: rtl/tri_bus_pkg.sv
// Shared types, default parameters and round-robin helper for the tristate bus arbiter.
package tri_bus_pkg;

   localparam int unsigned DefaultNDrv    = 4;
   localparam int unsigned DefaultWidth   = 8;
   localparam int unsigned DefaultMaxHold = 16;

   typedef enum logic [1:0] {StIdle, StGrant, StTurn} arb_state_e;

   // First requester found scanning upward from last+1, wrapping at n_drv (at most 16 drivers).
   function automatic logic [3:0] rr_winner(input logic [15:0]  req,
                                            input logic [3:0]   last,
                                            input int unsigned  n_drv);
      logic [3:0] idx;
      logic       found;
      rr_winner = 4'd0;
      found     = 1'b0;
      for (int unsigned k = 1; k <= 16; k++) begin
         idx = 4'((32'(last) + k) % n_drv);
         if (!found && (k <= n_drv) && req[idx]) begin
            found     = 1'b1;
            rr_winner = idx;
         end
      end
   endfunction

endpackage

// File: rtl/tri_drv.sv
// One WIDTH-bit tristate buffer: drives din onto bus when enabled, otherwise high impedance.
module tri_drv
   import tri_bus_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output tri   [WIDTH-1:0] bus
);

   assign bus = en ? din : {WIDTH{1'bz}};

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter placing one of N_DRV drivers on a shared tristate bus, one-cycle turnaround.
// Optional hold limit and timeout port are compiled in with TRI_BUS_HOLD_TIMEOUT_EN.
module tri_bus_arbiter
   import tri_bus_pkg::*;
#(
   parameter int unsigned N_DRV    = DefaultNDrv,
   parameter int unsigned WIDTH    = DefaultWidth,
   parameter int unsigned MAX_HOLD = DefaultMaxHold
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_DRV-1:0]         req,
   input  logic [N_DRV*WIDTH-1:0]   din,
   output logic [N_DRV-1:0]         gnt,
   output logic [$clog2(N_DRV)-1:0] owner,
   output logic                     busy,
`ifdef TRI_BUS_HOLD_TIMEOUT_EN
   output logic                     timeout,
`endif
   output tri   [WIDTH-1:0]         bus
);

   localparam int unsigned OwnerW = $clog2(N_DRV);

   if (N_DRV < 2 || N_DRV > 16 || MAX_HOLD < 1) begin : g_bad_param
      $error("tri_bus_arbiter: N_DRV must be 2..16 and MAX_HOLD at least 1");
   end

   arb_state_e        state_q, state_d;
   logic [N_DRV-1:0]  gnt_q, gnt_d;
   logic [OwnerW-1:0] owner_q, owner_d;
   logic [OwnerW-1:0] last_q, last_d;
   logic [OwnerW-1:0] winner;
   logic              expire;

   assign winner = OwnerW'(rr_winner(16'(req), 4'(last_q), N_DRV));

`ifdef TRI_BUS_HOLD_TIMEOUT_EN
   localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

   logic [HoldW-1:0] hold_q, hold_d;
   logic             timeout_q, timeout_d;

   // Counter is zero on the first GRANT cycle, so expiry lands on the MAX_HOLD-th cycle.
   assign expire = (state_q == StGrant) && (hold_q == HoldW'(MAX_HOLD - 1));

   always_comb begin
      hold_d    = (state_q == StGrant) ? hold_q + HoldW'(1) : '0;
      timeout_d = expire && req[owner_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (|req) state_d = StGrant;
         StGrant: if (!req[owner_q] || expire) state_d = StTurn;
         StTurn:  state_d = (|req) ? StGrant : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Grant, owner and priority pointer are registered so gnt changes only on the clock edge.
   always_comb begin
      gnt_d   = '0;
      owner_d = '0;
      last_d  = last_q;
      if (state_d == StGrant) begin
         owner_d        = (state_q == StGrant) ? owner_q : winner;
         gnt_d[owner_d] = 1'b1;
      end
      if (state_q == StGrant && state_d == StTurn) last_d = owner_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q   <= '0;
         owner_q <= '0;
         last_q  <= OwnerW'(N_DRV - 1);
      end else begin
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   assign gnt   = gnt_q;
   assign owner = owner_q;
   assign busy  = |gnt_q;

   for (genvar i = 0; i < N_DRV; i++) begin : g_drv
      tri_drv #(
         .WIDTH (WIDTH)
      ) u_drv (
         .en  (gnt_q[i]),
         .din (din[i*WIDTH +: WIDTH]),
         .bus (bus)
      );
   end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Scoreboard bench for tri_bus_arbiter: N_DRV=4, WIDTH=8; timeout scenario only with the macro.
module tb_tri_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = 4'b0000;
   logic [31:0] din = {8'h44, 8'h33, 8'h22, 8'hA5};
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic        busy;
   tri   [7:0]  bus;
`ifdef TRI_BUS_HOLD_TIMEOUT_EN
   logic        timeout;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] owner;
      logic       is_z;
      logic [7:0] data;
      logic       tmo;
   } exp_t;

   exp_t sb[$];

   tri_bus_arbiter #(
      .N_DRV    (4),
      .WIDTH    (8),
      .MAX_HOLD (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .din     (din),
      .gnt     (gnt),
      .owner   (owner),
      .busy    (busy),
`ifdef TRI_BUS_HOLD_TIMEOUT_EN
      .timeout (timeout),
`endif
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Scoreboard compare point plus per-cycle contention and x checks, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         n_tests++;
         if ((gnt & (gnt - 4'd1)) != 4'd0) begin
            n_fail++;
            $display("FAIL onehot: gnt=%b has more than one bit set at %0t", gnt, $time);
         end
         n_tests++;
         if (bus !== 8'bz && $isunknown(bus)) begin
            n_fail++;
            $display("FAIL bus_x: bus=%h resolved to x at %0t", bus, $time);
         end
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         n_tests++;
         if (gnt !== e.gnt) begin
            n_fail++;
            $display("FAIL gnt: got %b expected %b at %0t", gnt, e.gnt, $time);
         end
         n_tests++;
         if (owner !== e.owner) begin
            n_fail++;
            $display("FAIL owner: got %0d expected %0d at %0t", owner, e.owner, $time);
         end
         n_tests++;
         if (busy !== (e.gnt != 4'd0)) begin
            n_fail++;
            $display("FAIL busy: got %b expected %b at %0t", busy, e.gnt != 4'd0, $time);
         end
         n_tests++;
         if (e.is_z) begin
            if (bus !== 8'bz) begin
               n_fail++;
               $display("FAIL bus_z: got %h expected zz at %0t", bus, $time);
            end
         end else if (bus !== e.data) begin
            n_fail++;
            $display("FAIL bus_data: got %h expected %h at %0t", bus, e.data, $time);
         end
`ifdef TRI_BUS_HOLD_TIMEOUT_EN
         n_tests++;
         if (timeout !== e.tmo) begin
            n_fail++;
            $display("FAIL timeout: got %b expected %b at %0t", timeout, e.tmo, $time);
         end
`endif
      end
   end

   // Drive one cycle of stimulus and queue what the outputs must show during that cycle.
   task automatic drive(input logic r, input logic [3:0] q, input logic [3:0] eg,
                        input logic tmo = 1'b0);
      exp_t e;
      @(posedge clk);
      #1;
      rst     = r;
      req     = q;
      e.gnt   = eg;
      e.owner = eg[1] ? 2'd1 : eg[2] ? 2'd2 : eg[3] ? 2'd3 : 2'd0;
      e.is_z  = (eg == 4'd0);
      e.data  = din[e.owner*8 +: 8];
      e.tmo   = tmo;
      sb.push_back(e);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      req = 4'b0000;
      drive(1'b0, 4'b0000, 4'b0000);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      mon_en = 1'b1;
      drive(1'b1, 4'b1111, 4'b0000);
      @(negedge clk);
      #1;
      n_tests++;
      if (gnt !== 4'b0000 || owner !== 2'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: gnt=%b owner=%0d busy=%b expected 0/0/0", gnt, owner, busy);
      end
      drive(1'b0, 4'b0000, 4'b0000);
      drive(1'b0, 4'b0000, 4'b0000);
   endtask

   task automatic test_single();
      drive(1'b0, 4'b0001, 4'b0000);
      drive(1'b0, 4'b0001, 4'b0001);
      drive(1'b0, 4'b0001, 4'b0001);
      drive(1'b0, 4'b0000, 4'b0001);
      drive(1'b0, 4'b0000, 4'b0000);
      drive(1'b0, 4'b0000, 4'b0000);
   endtask

   task automatic test_simultaneous();
      logic [3:0] rq [16] = '{4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1100, 4'b1100,
                              4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0000,
                              4'b0000, 4'b0000};
      logic [3:0] eg [16] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                              4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001,
                              4'b0000, 4'b0000};
      pulse_reset();
      for (int i = 0; i < 16; i++) drive(1'b0, rq[i], eg[i]);
   endtask

   task automatic test_wrap();
      logic [3:0] rq [9] = '{4'b1000, 4'b1000, 4'b0001, 4'b1001, 4'b1000, 4'b1000, 4'b0000,
                             4'b0000, 4'b0000};
      logic [3:0] eg [9] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b1000,
                             4'b0000, 4'b0000};
      for (int i = 0; i < 9; i++) drive(1'b0, rq[i], eg[i]);
   endtask

   task automatic test_reset_mid_grant();
      drive(1'b0, 4'b0100, 4'b0000);
      drive(1'b1, 4'b0111, 4'b0100);
      drive(1'b0, 4'b0110, 4'b0000);
      @(negedge clk);
      #1;
      n_tests++;
      if (busy !== 1'b0 || gnt !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b gnt=%b expected 0/0000", busy, gnt);
      end
      drive(1'b0, 4'b0000, 4'b0010);
      drive(1'b0, 4'b0000, 4'b0000);
      drive(1'b0, 4'b0000, 4'b0000);
   endtask

   task automatic test_back_to_back();
      logic [3:0] rq [8] = '{4'b0010, 4'b0001, 4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                             4'b0000};
      logic [3:0] eg [8] = '{4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                             4'b0000};
      for (int i = 0; i < 8; i++) drive(1'b0, rq[i], eg[i]);
   endtask

`ifdef TRI_BUS_HOLD_TIMEOUT_EN
   task automatic test_timeout();
      logic [3:0] eg [14] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
                              4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
      pulse_reset();
      for (int i = 0; i < 14; i++) begin
         drive(1'b0, (i < 11) ? 4'b0011 : 4'b0000, eg[i], (i == 5) || (i == 10));
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_wrap();
      test_reset_mid_grant();
      test_back_to_back();
`ifdef TRI_BUS_HOLD_TIMEOUT_EN
      test_timeout();
`endif
      @(negedge clk);
      #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tri_bus_arbiter.md
TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 Parameter N_DRV, default 4, number of drivers sharing the bus (2..16).
REQ-002 Parameter WIDTH, default 8, bus width in bits.
REQ-003 Parameter MAX_HOLD, default 16, grant cycle limit; used only when the timeout feature is compiled in.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port req  input  N_DRV  per-driver bus request, level-sensitive.
REQ-007 Port din  input  N_DRV*WIDTH  per-driver data; driver i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port gnt  output  N_DRV  registered one-hot grant, or all-zero.
REQ-009 Port owner  output  $clog2(N_DRV)  index of the granted driver; 0 when no grant.
REQ-010 Port busy  output  1  high while any grant is active.
REQ-011 Port bus  output tri  WIDTH  shared net; exactly one driver or all high-impedance.

Function
REQ-012 The block SHALL never enable more than one driver onto bus in any cycle; bus SHALL never resolve to x from internal contention.
REQ-013 FSM states SHALL be IDLE, GRANT and TURN.
REQ-014 IDLE: when any req bit is sampled high, next state SHALL be GRANT, with gnt set to the round-robin winner at that same edge (1-cycle latency from req to gnt).
REQ-015 Round-robin: the search SHALL start at (last_owner+1) mod N_DRV and wrap past N_DRV-1 to 0; last_owner SHALL reset to N_DRV-1, so driver 0 has first priority after reset.
REQ-016 GRANT: bus SHALL equal din of owner; the grant SHALL be held while req[owner] stays high, regardless of other requests.
REQ-017 GRANT -> TURN SHALL occur at the edge where req[owner] is sampled low; at that edge gnt SHALL clear and last_owner SHALL update.
REQ-018 TURN SHALL last exactly one cycle with bus fully high-impedance (turnaround gap). It SHALL then go to GRANT, with a new round-robin winner, if any req is high; otherwise it SHALL go to IDLE.
REQ-019 A req dropped and re-raised by the owner during TURN SHALL be arbitrated like any other request; there is no back-to-back re-grant priority.
REQ-020 In IDLE and TURN, bus SHALL be z, gnt 0, busy 0, and owner SHALL hold 0.
REQ-021 busy SHALL equal |gnt.

Reset
REQ-022 rst high at any edge SHALL force IDLE, gnt=0, owner=0, busy=0, last_owner=N_DRV-1 and the hold counter to 0; bus SHALL be z from the following cycle.
REQ-023 Reset mid-GRANT SHALL drop the grant without a TURN cycle; req inputs SHALL be ignored while rst is high.

Configuration
REQ-024 Macro TRI_BUS_HOLD_TIMEOUT_EN, when defined, SHALL add a hold counter and output timeout (1 bit).
- The counter clears on entry to GRANT and counts each GRANT cycle.
- When the counter reaches MAX_HOLD, the FSM SHALL force GRANT -> TURN even if req[owner] is high, and timeout SHALL pulse high for that one cycle.
- The preempted owner SHALL then be lowest priority.
REQ-025 Without the macro, there SHALL be no counter and no timeout port, and a grant SHALL be held indefinitely.

Structure
REQ-026 Package tri_bus_pkg SHALL hold the FSM state enum, the default values of N_DRV, WIDTH and MAX_HOLD, and the round-robin next-winner function.
REQ-027 Sub-module tri_drv (a WIDTH-bit tristate buffer, enable -> din else z) SHALL be instantiated N_DRV times, all outputs tied to bus.

Verification
REQ-028 The bench SHALL use N_DRV=4, WIDTH=8 and declare the bus as a tri net. It SHALL check for x/z on bus during GRANT and x on bus at every edge.
REQ-029 Single request:
- Stimulus: req=0001, din0=8'hA5, held 3 cycles, then dropped.
- Required: gnt=0001 one edge after req, bus=A5 for 3 cycles, then one z cycle (TURN), then IDLE.
REQ-030 Simultaneous requests:
- Stimulus: req=1111 from reset, each owner drops its req after 2 cycles.
- Required: grant order 0,1,2,3,0; a z cycle between each grant; never two gnt bits high.
REQ-031 Wrap-around:
- Stimulus: last owner 3, then req=1001.
- Required: next gnt=0001; after it, gnt=1000.
REQ-032 Reset mid-grant:
- Stimulus: rst pulsed for 1 cycle while gnt=0100.
- Required: next cycle gnt=0000, busy=0, bus=z; after rst releases with req=0110, gnt=0010.
REQ-033 Timeout, with TRI_BUS_HOLD_TIMEOUT_EN and MAX_HOLD=4:
- Stimulus: req=0011 held high.
- Required: gnt=0001 for 4 cycles, timeout pulse, TURN, gnt=0010 for 4 cycles, alternating thereafter.
